// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the 16-bit pipelined CPU.
// Holds the PC, drives the instruction memory word address and fills the
// IF/ID pipeline register. Arbitrates boot, redirect, structural conflict
// and hazard stall events.
// Optional feature macro: FETCH_DELAY_SLOT_EN (one architectural delay slot
// after a taken branch/jump). Undefined: redirects squash the fetch slot.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        mem_conflict,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] fetch_addr,
    input  logic [15:0] fetch_instr,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_plus1,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e      state, state_next;
    logic [15:0] pc, pc_next;
    logic [15:0] pc_plus1;
    logic [15:0] instr_next;
    logic [15:0] pc_plus1_next;
    logic        valid_next;

`ifdef FETCH_DELAY_SLOT_EN
    logic [15:0] target, target_next;
`endif

    // Address wraps modulo 2^16 without any flag.
    assign pc_plus1   = pc + 16'd1;
    assign fetch_addr = pc;

    // Next-state and next-register decode, priority: redirect, conflict, stall.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_next    = state;
        pc_next       = pc;
        instr_next    = id_instr;
        pc_plus1_next = id_pc_plus1;
        valid_next    = id_valid;
`ifdef FETCH_DELAY_SLOT_EN
        target_next   = target;
`endif

        case (state)
            BOOT: begin
                // Memory output is not yet meaningful: insert a bubble.
                pc_next    = RESET_PC;
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
                state_next = RUN;
            end

            RUN: begin
                if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
                    if (mem_conflict) begin
                        // Delay slot not fetchable yet: park the target.
                        target_next = redirect_pc;
                        instr_next  = NOP_INSTR;
                        valid_next  = 1'b0;
                        state_next  = PEND;
                    end else begin
                        pc_next = redirect_pc;
                        if (!stall) begin
                            instr_next    = fetch_instr;
                            pc_plus1_next = pc_plus1;
                            valid_next    = 1'b1;
                        end
                    end
`else
                    // Squash whatever was fetched behind the branch.
                    pc_next    = redirect_pc;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
`endif
                end else if (mem_conflict) begin
                    // Fetch data is invalid; refetch the same PC next cycle.
                    if (!stall) begin
                        instr_next = NOP_INSTR;
                        valid_next = 1'b0;
                    end
                end else if (!stall) begin
                    pc_next       = pc_plus1;
                    instr_next    = fetch_instr;
                    pc_plus1_next = pc_plus1;
                    valid_next    = 1'b1;
                end
            end

`ifdef FETCH_DELAY_SLOT_EN
            PEND: begin
                // Further redirects are ignored until the delay slot issues.
                if (!mem_conflict && !stall) begin
                    instr_next    = fetch_instr;
                    pc_plus1_next = pc_plus1;
                    valid_next    = 1'b1;
                    pc_next       = target;
                    state_next    = RUN;
                end else if (!stall) begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
            end
`endif

            default: begin
                // Unreachable encodings recover into the normal flow.
                state_next = RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!RST) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc          <= RESET_PC;
            id_instr    <= NOP_INSTR;
            id_pc_plus1 <= 16'h0000;
            id_valid    <= 1'b0;
        end else begin
            pc          <= pc_next;
            id_instr    <= instr_next;
            id_pc_plus1 <= pc_plus1_next;
            id_valid    <= valid_next;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    // Latched branch target while a redirect waits out a memory conflict.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            target <= 16'h0000;
        end else begin
            target <= target_next;
        end
    end
`endif

endmodule
